uart_tx_arbiter: RTL and testbench

//   Shares one UART transmit line between NUM_REQ byte sources. Round-robin

---
 rtl/uart_tx_arbiter_if.sv | 21 ++
 rtl/uart_tx_arbiter.sv | 166 ++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 449 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
// Byte-source handshake bundle shared by all requesters of uart_tx_arbiter.
// Sources drive valid/data (master); the arbiter returns a one-hot ready (slave).
interface uart_tx_arbiter_if #(
  parameter int unsigned NUM_REQ = 2
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_ready;

  modport master (
    output req_valid,
    output req_data,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_data,
    output req_ready
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding a one-byte holding register and an 8N1/8N2
// UART frame sequencer paced by a one-cycle baud tick.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ   = 2,
  parameter int unsigned STOP_BITS = 1,
  parameter int unsigned ID_W      = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             baud_tick_i,
  uart_tx_arbiter_if.slave req,
  output logic             tx_o,
  output logic             busy_o,
  output logic [ID_W-1:0]  grant_id_o
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  localparam logic [1:0]      STOP_LAST  = 2'(STOP_BITS - 1);
  localparam logic [ID_W-1:0] LAST_RESET = ID_W'(NUM_REQ - 1);

  logic [1:0]      state_q,      state_d;
  logic            tx_q,         tx_d;
  logic [7:0]      shift_q,      shift_d;
  logic [2:0]      bit_cnt_q,    bit_cnt_d;
  logic [1:0]      stop_cnt_q,   stop_cnt_d;
  logic [ID_W-1:0] grant_id_q,   grant_id_d;
  logic [7:0]      hold_q,       hold_d;
  logic [ID_W-1:0] hold_id_q,    hold_id_d;
  logic            hold_valid_q, hold_valid_d;
  logic [ID_W-1:0] last_grant_q, last_grant_d;

  logic [NUM_REQ-1:0] ready;
  logic [ID_W-1:0]    pick_id;
  logic [7:0]         pick_data;
  logic               pick_found;
  logic               load;

  // Two passes give the wrap-around scan: first above last_grant, then from 0.
  // Ready is forced low while reset is asserted, even with valids present.
  always_comb begin
    ready      = '0;
    pick_id    = '0;
    pick_data  = '0;
    pick_found = 1'b0;
    if (!rst && !hold_valid_q) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (!pick_found && (i > 32'(last_grant_q)) && req.req_valid[i]) begin
          pick_found = 1'b1;
          pick_id    = ID_W'(i);
          pick_data  = req.req_data[8*i +: 8];
          ready[i]   = 1'b1;
        end
      end
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (!pick_found && (i <= 32'(last_grant_q)) && req.req_valid[i]) begin
          pick_found = 1'b1;
          pick_id    = ID_W'(i);
          pick_data  = req.req_data[8*i +: 8];
          ready[i]   = 1'b1;
        end
      end
    end
  end

  assign req.req_ready = ready;

  always_comb begin
    state_d    = state_q;
    tx_d       = tx_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    grant_id_d = grant_id_q;
    load       = 1'b0;
    if (baud_tick_i) begin
      case (state_q)
        ST_IDLE: begin
          if (hold_valid_q) load = 1'b1;
        end
        ST_START: begin
          state_d   = ST_DATA;
          tx_d      = shift_q[0];
          shift_d   = {1'b0, shift_q[7:1]};
          bit_cnt_d = '0;
        end
        ST_DATA: begin
          if (bit_cnt_q != 3'd7) begin
            tx_d      = shift_q[0];
            shift_d   = {1'b0, shift_q[7:1]};
            bit_cnt_d = bit_cnt_q + 3'd1;
          end else begin
            state_d    = ST_STOP;
            tx_d       = 1'b1;
            stop_cnt_d = '0;
          end
        end
        default: begin
          if (stop_cnt_q != STOP_LAST) begin
            stop_cnt_d = stop_cnt_q + 2'd1;
          end else if (hold_valid_q) begin
            load = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      endcase
    end
    // A pending hold byte starts the next frame straight from IDLE or the last stop bit.
    if (load) begin
      state_d    = ST_START;
      tx_d       = 1'b0;
      shift_d    = hold_q;
      grant_id_d = hold_id_q;
    end
  end

  // load and transfer are exclusive: a transfer needs hold_valid_q low, load needs it high.
  always_comb begin
    hold_d       = hold_q;
    hold_id_d    = hold_id_q;
    hold_valid_d = hold_valid_q;
    last_grant_d = last_grant_q;
    if (load) hold_valid_d = 1'b0;
    if (pick_found) begin
      hold_d       = pick_data;
      hold_id_d    = pick_id;
      hold_valid_d = 1'b1;
      last_grant_d = pick_id;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      tx_q         <= 1'b1;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      stop_cnt_q   <= '0;
      grant_id_q   <= '0;
      hold_q       <= '0;
      hold_id_q    <= '0;
      hold_valid_q <= 1'b0;
      last_grant_q <= LAST_RESET;
    end else begin
      state_q      <= state_d;
      tx_q         <= tx_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      stop_cnt_q   <= stop_cnt_d;
      grant_id_q   <= grant_id_d;
      hold_q       <= hold_d;
      hold_id_q    <= hold_id_d;
      hold_valid_q <= hold_valid_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign tx_o       = tx_q;
  assign busy_o     = (state_q != ST_IDLE) | hold_valid_q;
  assign grant_id_o = grant_id_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: dut1 runs 8N1, dut2 runs 8N2; baud tick every 4 clks.
module tb_uart_tx_arbiter;

  logic       clk;
  logic       rst;
  logic       tick;
  logic       tx1, busy1, tx2, busy2;
  logic [0:0] gid1, gid2;

  int tests;
  int fails;
  int cyc;
  int frames_done;

  logic [8:0] sb[$];
  int         ids[$];
  int         start_cyc[$];

  uart_tx_arbiter_if #(.NUM_REQ(2)) bus1 ();
  uart_tx_arbiter_if #(.NUM_REQ(2)) bus2 ();

  uart_tx_arbiter #(.NUM_REQ(2), .STOP_BITS(1), .ID_W(1)) dut1 (
    .clk(clk), .rst(rst), .baud_tick_i(tick), .req(bus1.slave),
    .tx_o(tx1), .busy_o(busy1), .grant_id_o(gid1)
  );

  uart_tx_arbiter #(.NUM_REQ(2), .STOP_BITS(2), .ID_W(1)) dut2 (
    .clk(clk), .rst(rst), .baud_tick_i(tick), .req(bus2.slave),
    .tx_o(tx2), .busy_o(busy2), .grant_id_o(gid2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    int phase;
    phase = 0;
    tick  = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      tick  = (phase == 3);
      phase = (phase + 1) % 4;
    end
  end

  // Frame decoder for dut1: checks every clock of every bit against the popped expectation.
  initial begin : monitor
    logic       prev;
    logic       have;
    logic [8:0] exp;
    logic [7:0] got;
    logic [0:0] gid;
    logic       abort;
    logic       ebit;
    int         errs;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev = 1'b1;
      end else begin
        if (prev === 1'b1 && tx1 === 1'b0) begin
          have = (sb.size() != 0);
          exp  = 9'h0;
          if (have) exp = sb.pop_front();
          ids.push_back(int'(gid1));
          start_cyc.push_back(cyc);
          gid   = gid1;
          got   = '0;
          errs  = 0;
          abort = 1'b0;
          for (int b = 0; b < 10; b++) begin
            for (int s = 0; s < 4; s++) begin
              if (!abort) begin
                if (b != 0 || s != 0) @(negedge clk);
                if (rst) begin
                  abort = 1'b1;
                end else begin
                  if (b == 0) ebit = 1'b0;
                  else if (b == 9) ebit = 1'b1;
                  else ebit = exp[b-1];
                  if (tx1 !== ebit) errs++;
                  if (s == 2 && b >= 1 && b <= 8) got[b-1] = tx1;
                end
              end
            end
          end
          if (!abort) begin
            tests++;
            frames_done++;
            if (!have || errs != 0 || gid !== exp[8]) begin
              fails++;
              $display("FAIL frame: got id=%0d byte=%02h (%0d bad bit samples), expected id=%0d byte=%02h%s",
                       gid, got, errs, exp[8], exp[7:0], have ? "" : " (no frame was expected)");
            end
          end
        end
        prev = rst ? 1'b1 : tx1;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d fails=%0d", tests, fails);
    $fatal(1, "watchdog expired");
  end

  task automatic apply_reset;
    @(posedge clk); #2;
    rst = 1'b1;
    bus1.req_valid = '0;
    bus2.req_valid = '0;
    repeat (3) @(posedge clk);
    #2;
    sb.delete();
    ids.delete();
    start_cyc.delete();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #2;
  endtask

  task automatic source1(input int id, input logic [7:0] d, input int n);
    int k;
    logic acc;
    @(posedge clk); #2;
    for (int j = 0; j < n; j++) begin
      bus1.req_valid[id]        = 1'b1;
      bus1.req_data[8*id +: 8]  = d;
      k   = 0;
      acc = 1'b0;
      while (!acc && k < 400) begin
        @(negedge clk);
        if (bus1.req_ready[id] === 1'b1) begin
          acc = 1'b1;
          sb.push_back({id[0], d});
        end
        @(posedge clk); #2;
        k++;
      end
      tests++;
      if (!acc) begin
        fails++;
        $display("FAIL accept_req%0d: ready not seen in %0d cycles, required ready=1", id, k);
      end
    end
    bus1.req_valid[id] = 1'b0;
  endtask

  task automatic wait_frames(input int target, input string what);
    int n;
    n = 0;
    while (frames_done < target && n < 2000) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (frames_done < target) begin
      fails++;
      $display("FAIL %s: frames seen %0d, required %0d", what, frames_done, target);
    end
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL %s_leftover: %0d expected bytes never transmitted, required 0", what, sb.size());
    end
  endtask

  task automatic test_reset;
    @(posedge clk); #2;
    rst = 1'b1;
    bus1.req_valid = 2'b11;
    bus1.req_data  = 16'h2211;
    bus2.req_valid = 2'b11;
    bus2.req_data  = 16'h4433;
    @(negedge clk);
    tests++;
    if (tx1 !== 1'b1 || busy1 !== 1'b0 || bus1.req_ready !== 2'b00 || gid1 !== 1'b0) begin
      fails++;
      $display("FAIL reset_dut1: tx=%b busy=%b ready=%b gid=%b, required tx=1 busy=0 ready=00 gid=0",
               tx1, busy1, bus1.req_ready, gid1);
    end
    tests++;
    if (tx2 !== 1'b1 || busy2 !== 1'b0 || bus2.req_ready !== 2'b00) begin
      fails++;
      $display("FAIL reset_dut2: tx=%b busy=%b ready=%b, required tx=1 busy=0 ready=00",
               tx2, busy2, bus2.req_ready);
    end
    @(posedge clk); #2;
    bus1.req_valid = '0;
    bus2.req_valid = '0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if (tx1 !== 1'b1 || busy1 !== 1'b0 || bus1.req_ready !== 2'b00) begin
      fails++;
      $display("FAIL idle_after_reset: tx=%b busy=%b ready=%b, required tx=1 busy=0 ready=00",
               tx1, busy1, bus1.req_ready);
    end
    @(posedge clk); #2;
    bus1.req_valid = 2'b11;
    @(negedge clk);
    tests++;
    if (bus1.req_ready !== 2'b01) begin
      fails++;
      $display("FAIL first_grant: ready=%b, required 01", bus1.req_ready);
    end
    #1 bus1.req_valid = '0;
    @(posedge clk); #2;
    tests++;
    if (busy1 !== 1'b0) begin
      fails++;
      $display("FAIL no_transfer: busy=%b, required 0", busy1);
    end
  endtask

  task automatic test_single_byte;
    int f0, n, cnt;
    apply_reset();
    f0 = frames_done;
    source1(0, 8'hA5, 1);
    bus1.req_valid[0] = 1'b1;
    @(negedge clk);
    tests++;
    if (bus1.req_ready !== 2'b00) begin
      fails++;
      $display("FAIL ready_one_clk: ready=%b with hold full, required 00", bus1.req_ready);
    end
    #1 bus1.req_valid[0] = 1'b0;
    n = 0;
    while (tx1 !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    cnt = 0;
    while (busy1 === 1'b1 && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    tests++;
    if (cnt != 40) begin
      fails++;
      $display("FAIL busy_span: busy high for %0d clks from start bit, required 40", cnt);
    end
    wait_frames(f0 + 1, "single_byte");
  endtask

  task automatic test_round_robin;
    int f0;
    int exp_ids[4];
    exp_ids = '{0, 1, 0, 1};
    apply_reset();
    f0 = frames_done;
    fork
      source1(0, 8'h11, 2);
      source1(1, 8'h22, 2);
    join
    wait_frames(f0 + 4, "round_robin");
    tests++;
    if (ids.size() != 4) begin
      fails++;
      $display("FAIL rr_count: %0d frames started, required 4", ids.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        tests++;
        if (ids[k] != exp_ids[k]) begin
          fails++;
          $display("FAIL rr_grant%0d: grant_id=%0d, required %0d", k, ids[k], exp_ids[k]);
        end
      end
      for (int k = 1; k < 4; k++) begin
        tests++;
        if (start_cyc[k] - start_cyc[k-1] != 40) begin
          fails++;
          $display("FAIL back_to_back%0d: start spacing %0d clks, required 40",
                   k, start_cyc[k] - start_cyc[k-1]);
        end
      end
    end
  endtask

  task automatic test_two_stop_bits;
    apply_reset();
    fork
      begin : src2
        int acc, k;
        acc = 0;
        k   = 0;
        bus2.req_data     = '0;
        bus2.req_valid[0] = 1'b1;
        while (acc < 2 && k < 400) begin
          @(negedge clk);
          if (bus2.req_ready[0] === 1'b1) acc++;
          @(posedge clk); #2;
          k++;
        end
        bus2.req_valid[0] = 1'b0;
        tests++;
        if (acc != 2) begin
          fails++;
          $display("FAIL stop2_accepts: %0d bytes accepted, required 2", acc);
        end
      end
      begin : obs2
        int n, low1, gap, low2, tail;
        n = 0;
        while (tx2 !== 1'b0 && n < 200) begin
          @(negedge clk);
          n++;
        end
        low1 = 0;
        while (tx2 === 1'b0 && low1 < 200) begin low1++; @(negedge clk); end
        gap = 0;
        while (tx2 === 1'b1 && gap < 200) begin gap++; @(negedge clk); end
        low2 = 0;
        while (tx2 === 1'b0 && low2 < 200) begin low2++; @(negedge clk); end
        tail = 0;
        while (busy2 === 1'b1 && tail < 200) begin tail++; @(negedge clk); end
        tests++;
        if (low1 != 36 || low2 != 36) begin
          fails++;
          $display("FAIL stop2_low: low spans %0d and %0d clks, required 36 and 36", low1, low2);
        end
        tests++;
        if (gap != 8) begin
          fails++;
          $display("FAIL stop2_gap: tx high %0d clks between frames, required 8", gap);
        end
        tests++;
        if (tail != 8 || tx2 !== 1'b1) begin
          fails++;
          $display("FAIL stop2_tail: busy held %0d clks after bit 7 (tx=%b), required 8 (tx=1)", tail, tx2);
        end
      end
    join
  endtask

  task automatic test_reset_mid_frame;
    int f0, n;
    apply_reset();
    source1(0, 8'h3C, 1);
    n = 0;
    while (tx1 !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (tx1 !== 1'b0) begin
      fails++;
      $display("FAIL mid_start: tx=%b after %0d clks, required 0", tx1, n);
    end
    source1(0, 8'hC3, 1);
    repeat (10) @(negedge clk);
    tests++;
    if (busy1 !== 1'b1) begin
      fails++;
      $display("FAIL mid_busy: busy=%b mid-frame, required 1", busy1);
    end
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    tests++;
    if (tx1 !== 1'b1 || busy1 !== 1'b0 || bus1.req_ready !== 2'b00) begin
      fails++;
      $display("FAIL mid_reset: tx=%b busy=%b ready=%b, required tx=1 busy=0 ready=00",
               tx1, busy1, bus1.req_ready);
    end
    repeat (3) @(posedge clk);
    #2;
    sb.delete();
    f0  = frames_done;
    rst = 1'b0;
    source1(1, 8'h5A, 1);
    wait_frames(f0 + 1, "after_reset");
    repeat (60) @(negedge clk);
    tests++;
    if (frames_done != f0 + 1) begin
      fails++;
      $display("FAIL discarded_hold: %0d frames after reset, required 1", frames_done - f0);
    end
  endtask

  task automatic test_tick_transfer;
    int f0, n;
    apply_reset();
    f0 = frames_done;
    n  = 0;
    while (tick !== 1'b1 && n < 10) begin
      @(posedge clk); #2;
      n++;
    end
    bus1.req_valid[1]  = 1'b1;
    bus1.req_data[15:8] = 8'h96;
    @(negedge clk);
    tests++;
    if (bus1.req_ready !== 2'b10 || tick !== 1'b1) begin
      fails++;
      $display("FAIL tick_xfer: ready=%b tick=%b, required ready=10 tick=1", bus1.req_ready, tick);
    end
    sb.push_back({1'b1, 8'h96});
    @(posedge clk); #2;
    bus1.req_valid[1]  = 1'b0;
    bus1.req_valid[0]  = 1'b1;
    bus1.req_data[7:0] = 8'h69;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      tests++;
      if (tx1 !== 1'b1 || bus1.req_ready !== 2'b00) begin
        fails++;
        $display("FAIL tick_wait%0d: tx=%b ready=%b, required tx=1 ready=00", k, tx1, bus1.req_ready);
      end
    end
    @(negedge clk);
    tests++;
    if (tx1 !== 1'b0 || bus1.req_ready !== 2'b01) begin
      fails++;
      $display("FAIL tick_start: tx=%b ready=%b, required tx=0 ready=01", tx1, bus1.req_ready);
    end
    sb.push_back({1'b0, 8'h69});
    @(posedge clk); #2;
    bus1.req_valid[0] = 1'b0;
    wait_frames(f0 + 2, "tick_transfer");
  endtask

  initial begin
    tests          = 0;
    fails          = 0;
    cyc            = 0;
    frames_done    = 0;
    rst            = 1'b1;
    bus1.req_valid = '0;
    bus1.req_data  = '0;
    bus2.req_valid = '0;
    bus2.req_data  = '0;
    test_reset();
    test_single_byte();
    test_round_robin();
    test_two_stop_bits();
    test_reset_mid_frame();
    test_tick_transfer();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
